// File: rtl/systolic_ctrl.sv
// Weight-stationary array sequencer: fill one NxN weight tile, shift it in over N unbroken cycles, switch, skew K vectors in, drain.
// Array-side outputs are registered (skew row r adds r+1 cycles); w_ready/x_ready/busy decode from state, so producers stall outside FILL/STREAM.
module systolic_ctrl #(
  parameter int N     = 4,
  parameter int DW    = 8,
  parameter int LEN_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LEN_W-1:0]  cfg_len,
  input  logic [N*DW-1:0]   w_data,
  input  logic              w_valid,
  output logic              w_ready,
  input  logic [N*DW-1:0]   x_data,
  input  logic              x_valid,
  output logic              x_ready,
  output logic [N*DW-1:0]   sa_weight,
  output logic              sa_accept_w,
  output logic [N-1:0]      sa_switch,
  output logic [N*DW-1:0]   sa_input,
  output logic [N-1:0]      sa_valid,
  output logic              sa_enable,
  output logic              busy,
  output logic              done
);

  localparam int CW  = (N > 1) ? $clog2(N) : 1;
  localparam int DCW = $clog2(3 * N);

  typedef enum logic [2:0] {
    S_IDLE, S_FILL, S_SHIFT, S_SWITCH, S_STREAM, S_DRAIN, S_DONE
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [LEN_W-1:0]   len_q;
  logic [LEN_W-1:0]   vcnt;
  logic [CW-1:0]      cnt;
  logic [CW-1:0]      cnt_inc;
  logic               cnt_last;
  logic [CW-1:0]      shift_idx;
  logic [DCW-1:0]     dcnt;
  logic [N*DW-1:0]    wbuf [N];
  logic               w_hs;
  logic               x_hs;
  logic [DW-1:0]      tap_d [N];
  logic               tap_v [N];

  assign w_hs      = w_valid & w_ready;
  assign x_hs      = x_valid & x_ready;
  assign cnt_inc   = cnt + CW'(1);
  assign cnt_last  = (cnt == CW'(N - 1));
  // Row to present on the next SHIFT cycle; outputs are registered from next-state
  assign shift_idx = (state == S_SHIFT) ? cnt_inc : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (start) state_nxt = S_FILL;
      S_FILL:   if (w_hs && cnt_last) state_nxt = S_SHIFT;
      S_SHIFT:  if (cnt_last) state_nxt = S_SWITCH;
      S_SWITCH: state_nxt = (len_q != '0) ? S_STREAM : S_DRAIN;
      S_STREAM: if (x_hs && (vcnt == len_q - LEN_W'(1))) state_nxt = S_DRAIN;
      S_DRAIN:  if (dcnt == DCW'(3 * N - 1)) state_nxt = S_DONE;
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_ready = (state == S_FILL);
    x_ready = (state == S_STREAM);
    busy    = (state != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_q <= '0;
      vcnt  <= '0;
      cnt   <= '0;
      dcnt  <= '0;
      for (int i = 0; i < N; i++) wbuf[i] <= '0;
    end else begin
      if (state == S_IDLE && start) len_q <= cfg_len;
      case (state)
        S_FILL: if (w_hs) begin
          wbuf[cnt] <= w_data;
          cnt       <= cnt_last ? '0 : cnt_inc;
        end
        S_SHIFT: cnt <= cnt_last ? '0 : cnt_inc;
        default: ;
      endcase
      if (state == S_SWITCH) vcnt <= '0;
      else if (x_hs)         vcnt <= vcnt + LEN_W'(1);
      if (state == S_DRAIN)  dcnt <= dcnt + DCW'(1);
      else                   dcnt <= '0;
    end
  end

  // The accept burst must stay contiguous: a low accept zeroes the column shift path
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sa_enable   <= 1'b0;
      sa_accept_w <= 1'b0;
      sa_weight   <= '0;
      sa_switch   <= '0;
      done        <= 1'b0;
    end else begin
      sa_enable   <= 1'b1;
      sa_accept_w <= (state_nxt == S_SHIFT);
      sa_weight   <= (state_nxt == S_SHIFT) ? wbuf[shift_idx] : '0;
      sa_switch   <= (state_nxt == S_SWITCH) ? '1 : '0;
      done        <= (state_nxt == S_DONE);
    end
  end

  for (genvar r = 0; r < N; r++) begin : g_skew
    logic [DW-1:0] sd [r+1];
    logic [r:0]    sv;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int k = 0; k <= r; k++) sd[k] <= '0;
        sv <= '0;
      end else begin
        sd[0] <= x_hs ? x_data[r*DW +: DW] : '0;
        sv[0] <= x_hs;
        for (int k = 1; k <= r; k++) begin
          sd[k] <= sd[k-1];
          sv[k] <= sv[k-1];
        end
      end
    end

    assign tap_d[r] = sd[r];
    assign tap_v[r] = sv[r];
  end

  always_comb begin
    sa_input = '0;
    sa_valid = '0;
    for (int r = 0; r < N; r++) begin
      sa_input[r*DW +: DW] = tap_d[r];
      sa_valid[r]          = tap_v[r];
    end
  end

endmodule

// File: tb/tb_systolic_ctrl.sv
// Bench for systolic_ctrl (N=4): scoreboard of weight rows and activation handshakes checked at the array edge.
module tb_systolic_ctrl;
  localparam int N = 4;
  localparam int DW = 8;
  localparam int LEN_W = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic [LEN_W-1:0] cfg_len = '0;
  logic [N*DW-1:0] w_data = '0;
  logic w_valid = 1'b0;
  logic w_ready;
  logic [N*DW-1:0] x_data = '0;
  logic x_valid = 1'b0;
  logic x_ready;
  logic [N*DW-1:0] sa_weight;
  logic sa_accept_w;
  logic [N-1:0] sa_switch;
  logic [N*DW-1:0] sa_input;
  logic [N-1:0] sa_valid;
  logic sa_enable, busy, done;

  systolic_ctrl #(.N(N), .DW(DW), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_len(cfg_len),
    .w_data(w_data), .w_valid(w_valid), .w_ready(w_ready),
    .x_data(x_data), .x_valid(x_valid), .x_ready(x_ready),
    .sa_weight(sa_weight), .sa_accept_w(sa_accept_w), .sa_switch(sa_switch),
    .sa_input(sa_input), .sa_valid(sa_valid), .sa_enable(sa_enable),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct { int c; logic [N*DW-1:0] d; } hs_t;
  hs_t hist[$];
  logic [N*DW-1:0] wq[$];
  logic [N*DW-1:0] wrow [N];
  int ptr [N];
  int vcount [N];
  int first_vc [N];
  logic [DW-1:0] first_vd [N];
  int acc_runs = 0, acc_len = 0, last_run_len = 0, last_acc_end = 0;
  bit prev_acc = 0;
  int sw_count = 0, sw_cycle = 0, done_count = 0, done_cycle = 0, xr_count = 0;
  logic [N-1:0] sw_val = '0;

  // Scoreboard: handshakes are pushed as they happen, array-edge outputs pop and compare
  always @(negedge clk) begin : mon
    hs_t h;
    hs_t e;
    logic [N*DW-1:0] ew;
    if (rst) begin
      wq.delete();
      hist.delete();
      for (int r = 0; r < N; r++) ptr[r] = 0;
      prev_acc = 0;
    end else begin
      if (w_valid && w_ready) wq.push_back(w_data);
      if (x_valid && x_ready) begin h.c = cyc; h.d = x_data; hist.push_back(h); end
      if (sa_accept_w) begin
        n_checks++;
        if (wq.size() == 0) begin
          n_fail++; $display("FAIL sb_weight: sa_weight=%h at cycle %0d, no row queued", sa_weight, cyc);
        end else begin
          ew = wq.pop_front();
          if (sa_weight !== ew) begin
            n_fail++; $display("FAIL sb_weight: got %h expected %h", sa_weight, ew);
          end
        end
        if (!prev_acc) begin acc_runs++; acc_len = 1; end else acc_len++;
      end else if (prev_acc) begin
        last_run_len = acc_len; last_acc_end = cyc - 1;
      end
      prev_acc = sa_accept_w;
      if (sa_switch !== '0) begin sw_count++; sw_val = sa_switch; sw_cycle = cyc; end
      if (done) begin done_count++; done_cycle = cyc; end
      if (x_ready) xr_count++;
      for (int r = 0; r < N; r++) begin
        n_checks++;
        if (sa_valid[r]) begin
          if (ptr[r] >= hist.size()) begin
            n_fail++; $display("FAIL sb_row%0d: valid at cycle %0d with no handshake pending", r, cyc);
          end else begin
            e = hist[ptr[r]]; ptr[r]++;
            if (vcount[r] == 0) begin first_vc[r] = cyc; first_vd[r] = sa_input[r*DW +: DW]; end
            vcount[r]++;
            if (sa_input[r*DW +: DW] !== e.d[r*DW +: DW] || cyc != e.c + r + 1)
              begin
                n_fail++;
                $display("FAIL sb_row%0d: got %h at cycle %0d expected %h at cycle %0d",
                         r, sa_input[r*DW +: DW], cyc, e.d[r*DW +: DW], e.c + r + 1);
              end
          end
        end else if (sa_input[r*DW +: DW] !== '0) begin
          n_fail++; $display("FAIL bubble_row%0d: data %h while valid=0", r, sa_input[r*DW +: DW]);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic sb_new_job();
    hist.delete();
    wq.delete();
    for (int r = 0; r < N; r++) begin ptr[r] = 0; vcount[r] = 0; first_vc[r] = 0; first_vd[r] = '0; end
  endtask

  task automatic send_w(input logic [N*DW-1:0] d, output bit to);
    bit hs; int n;
    w_data = d; w_valid = 1; hs = 0; n = 0;
    while (!hs && n < 100) begin @(negedge clk); hs = w_ready; @(posedge clk); #1; n++; end
    w_valid = 0; to = !hs;
  endtask

  task automatic send_x(input logic [N*DW-1:0] d, output bit to);
    bit hs; int n;
    x_data = d; x_valid = 1; hs = 0; n = 0;
    while (!hs && n < 100) begin @(negedge clk); hs = x_ready; @(posedge clk); #1; n++; end
    x_valid = 0; x_data = '0; to = !hs;
  endtask

  task automatic drive_job(input int k, input int wgap, input int mask, input bit rnd,
                           input bit poke, output bit to, output bit busy_after);
    bit t, seen; int n; logic [N*DW-1:0] xd;
    to = 0; busy_after = 0;
    start = 1; cfg_len = LEN_W'(k); step(); start = 0; cfg_len = LEN_W'(k + 7);
    for (int i = 0; i < N; i++) begin
      send_w(wrow[i], t); to |= t;
      if (i < N - 1) repeat (wgap) step();
    end
    if (poke) begin start = 1; cfg_len = LEN_W'(9); step(); start = 0; end
    for (int j = 0; j < k; j++) begin
      if (j > 0 && mask[j]) begin x_valid = 0; step(); end
      for (int r = 0; r < N; r++) xd[r*DW +: DW] = rnd ? DW'($urandom) : DW'(j * 16 + r + 1);
      send_x(xd, t); to |= t;
    end
    seen = 0; n = 0;
    while (!seen && n < 200) begin
      @(negedge clk); seen = done;
      if (seen && poke) start = 1;
      @(posedge clk); #1; n++;
    end
    start = 0; busy_after = busy; to |= !seen;
  endtask

  task automatic test_reset();
    bit t; int d0;
    rst = 0; #1 rst = 1; #3;
    n_checks++;
    if ({sa_weight, sa_accept_w, sa_switch, sa_input, sa_valid, sa_enable, busy, done, w_ready, x_ready} !== '0) begin
      n_fail++; $display("FAIL reset_outputs: some output nonzero under reset (enable=%b busy=%b)", sa_enable, busy);
    end
    @(negedge clk); rst = 0; #1;
    n_checks++;
    if (sa_enable !== 1'b0) begin n_fail++; $display("FAIL enable_before_clk: got %b expected 0", sa_enable); end
    @(posedge clk); #1;
    n_checks++;
    if (sa_enable !== 1'b1) begin n_fail++; $display("FAIL enable_after_clk: got %b expected 1", sa_enable); end
    // abort a job in the middle of streaming
    for (int i = 0; i < N; i++) wrow[i] = {N{8'h5A}};
    sb_new_job();
    start = 1; cfg_len = LEN_W'(5); step(); start = 0;
    for (int i = 0; i < N; i++) send_w(wrow[i], t);
    send_x(32'h0403_0201, t);
    send_x(32'h1413_1211, t);
    x_valid = 1; x_data = 32'h2423_2221;
    d0 = done_count;
    #3 rst = 1; #1;
    n_checks++;
    if ({sa_weight, sa_accept_w, sa_switch, sa_input, sa_valid, sa_enable, busy, done, w_ready, x_ready} !== '0) begin
      n_fail++; $display("FAIL reset_midjob: outputs nonzero (valid=%b busy=%b x_ready=%b)", sa_valid, busy, x_ready);
    end
    x_valid = 0;
    repeat (2) step();
    @(negedge clk); rst = 0;
    @(posedge clk); #1;
    n_checks++;
    if (sa_enable !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_recover: enable=%b busy=%b expected 1/0", sa_enable, busy);
    end
    repeat (3) step();
    n_checks++;
    if (done_count != d0) begin n_fail++; $display("FAIL reset_no_done: %0d done pulses, expected 0", done_count - d0); end
  endtask

  task automatic check_rows(input string nm, input int k);
    // verifies every row consumed exactly the k handshakes of this job
    for (int r = 0; r < N; r++) begin
      n_checks++;
      if (ptr[r] != k || hist.size() != k) begin
        n_fail++; $display("FAIL %s_row%0d: consumed %0d of %0d handshakes, expected %0d", nm, r, ptr[r], hist.size(), k);
      end
    end
  endtask

  task automatic test_load();
    bit to, ba; int a0, s0;
    wrow[0] = 32'h1111_1111; wrow[1] = 32'h2222_2222; wrow[2] = 32'h3333_3333; wrow[3] = 32'h4444_4444;
    sb_new_job(); a0 = acc_runs; s0 = sw_count;
    drive_job(1, 1, 0, 0, 0, to, ba);
    n_checks++;
    if (to) begin n_fail++; $display("FAIL load_timeout: job did not finish"); end
    n_checks++;
    if (acc_runs - a0 != 1 || last_run_len != N) begin
      n_fail++; $display("FAIL load_burst: %0d bursts, last length %0d, expected 1 burst of %0d", acc_runs - a0, last_run_len, N);
    end
    n_checks++;
    if (wq.size() != 0) begin n_fail++; $display("FAIL load_rows_left: %0d rows never shifted, expected 0", wq.size()); end
    n_checks++;
    if (sw_count - s0 != 1 || sw_val !== 4'b1111) begin
      n_fail++; $display("FAIL load_switch: %0d switch cycles value %b, expected 1 of 1111", sw_count - s0, sw_val);
    end
    n_checks++;
    if (sw_cycle != last_acc_end + 1) begin
      n_fail++; $display("FAIL load_switch_time: switch at %0d, expected %0d", sw_cycle, last_acc_end + 1);
    end
    check_rows("load", 1);
  endtask

  task automatic test_skew();
    bit to, ba;
    sb_new_job();
    drive_job(3, 0, 0, 0, 0, to, ba);
    n_checks++;
    if (to) begin n_fail++; $display("FAIL skew_timeout: job did not finish"); end
    check_rows("skew", 3);
    if (hist.size() == 3) begin
      n_checks++;
      if (hist[2].c - hist[0].c != 2) begin
        n_fail++; $display("FAIL skew_hs_span: handshakes span %0d cycles, expected 2", hist[2].c - hist[0].c);
      end
      for (int r = 0; r < N; r++) begin
        n_checks++;
        if (vcount[r] != 3 || first_vc[r] != hist[0].c + r + 1) begin
          n_fail++; $display("FAIL skew_row%0d: %0d valid cycles first at %0d, expected 3 first at %0d",
                             r, vcount[r], first_vc[r], hist[0].c + r + 1);
        end
      end
    end
    n_checks++;
    if (first_vd[3] !== 8'h04) begin n_fail++; $display("FAIL skew_row3_data: got %h expected 04", first_vd[3]); end
  endtask

  task automatic test_bubbles();
    bit to, ba;
    sb_new_job();
    drive_job(2, 0, 32'b10, 0, 0, to, ba);
    n_checks++;
    if (to) begin n_fail++; $display("FAIL bubble_timeout: job did not finish"); end
    check_rows("bubble", 2);
    if (hist.size() == 2) begin
      n_checks++;
      if (hist[1].c - hist[0].c != 2) begin
        n_fail++; $display("FAIL bubble_gap: handshakes %0d apart, expected 2", hist[1].c - hist[0].c);
      end
    end
  endtask

  task automatic test_k0();
    bit to, ba; int x0, d0;
    for (int i = 0; i < N; i++) wrow[i] = $urandom;
    sb_new_job(); x0 = xr_count; d0 = done_count;
    drive_job(0, 0, 0, 0, 0, to, ba);
    n_checks++;
    if (to) begin n_fail++; $display("FAIL k0_timeout: job did not finish"); end
    n_checks++;
    if (xr_count != x0) begin n_fail++; $display("FAIL k0_x_ready: high %0d cycles, expected 0", xr_count - x0); end
    n_checks++;
    if (done_count - d0 != 1) begin n_fail++; $display("FAIL k0_done_count: %0d pulses, expected 1", done_count - d0); end
    n_checks++;
    if (done_cycle - sw_cycle != 3 * N + 1) begin
      n_fail++; $display("FAIL k0_drain: done %0d cycles after switch, expected %0d", done_cycle - sw_cycle, 3 * N + 1);
    end
  endtask

  task automatic test_busy_start();
    bit to, ba;
    for (int i = 0; i < N; i++) wrow[i] = $urandom;
    sb_new_job();
    drive_job(3, 0, 0, 1, 1, to, ba);
    n_checks++;
    if (to) begin n_fail++; $display("FAIL busy_start_timeout: first job did not finish"); end
    check_rows("busy_start", 3);
    n_checks++;
    if (ba !== 1'b0) begin n_fail++; $display("FAIL busy_start_done: busy=%b after start in DONE, expected 0", ba); end
    sb_new_job();
    drive_job(2, 2, 0, 1, 0, to, ba);
    n_checks++;
    if (to) begin n_fail++; $display("FAIL back_to_back_timeout: second job did not finish"); end
    check_rows("back_to_back", 2);
  endtask

  task automatic test_random();
    bit to, ba; int k;
    k = 6;
    for (int i = 0; i < N; i++) wrow[i] = $urandom;
    sb_new_job();
    drive_job(k, $urandom_range(0, 2), int'($urandom) & 32'h3E, 1, 0, to, ba);
    n_checks++;
    if (to) begin n_fail++; $display("FAIL random_timeout: job did not finish"); end
    check_rows("random", k);
    n_checks++;
    if (wq.size() != 0) begin n_fail++; $display("FAIL random_rows_left: %0d rows, expected 0", wq.size()); end
  endtask

  initial begin
    test_reset();
    test_load();
    test_skew();
    test_bubbles();
    test_k0();
    test_busy_start();
    test_random();
    repeat (2) step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end
endmodule
